// File: rtl/alu_seq_if.sv
// Handshake and datapath-control bundle between the sequencer
// and the datapath/instruction source it drives.
interface alu_seq_if #(
  parameter int N    = 10,
  parameter int NREG = 4
);
  logic [N-1:0]    INSTR;
  logic            PEXEC;
  logic            BUSY;
  logic            DONE;
  logic            ERR;
  logic [3:0]      FN;
  logic            Ain;
  logic            Gin;
  logic            Gout;
  logic            IRout;
  logic            IMMout;
  logic [N-1:0]    IMM;
  logic [NREG-1:0] Rin;
  logic [NREG-1:0] Rout;

  modport master (
    output INSTR, PEXEC,
    input  BUSY, DONE, ERR, FN, Ain, Gin, Gout,
    input  IRout, IMMout, IMM, Rin, Rout
  );

  modport slave (
    input  INSTR, PEXEC,
    output BUSY, DONE, ERR, FN, Ain, Gin, Gout,
    output IRout, IMMout, IMM, Rin, Rout
  );
endinterface

// File: rtl/alu_sequencer.sv
// Multi-cycle control FSM stepping the shared bus/ALU datapath
// through DEC/T1/T2/T3 for one latched instruction at a time.
module alu_sequencer #(
  parameter int N    = 10,
  parameter int NREG = 4
) (
  input  logic      CLKb,
  input  logic      RSTb,
  alu_seq_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_DEC, S_T1, S_T2, S_T3
  } state_t;

  state_t         r_state;
  logic [N-1:0]   r_ir;

  logic [1:0]     w_cls;
  logic [3:0]     w_fnc;
  logic [1:0]     w_sub;
  logic           w_rtype;
  logic           w_move;
  logic           w_legal;
  logic           w_mv;
  logic           w_mvi;
  logic [1:0]     w_rx;
  logic [1:0]     w_ry;

  logic            w_busy;
  logic            w_done;
  logic            w_err;
  logic [3:0]      w_fn;
  logic            w_ain;
  logic            w_gin;
  logic            w_gout;
  logic            w_irout;
  logic            w_immout;
  logic [NREG-1:0] w_rin;
  logic [NREG-1:0] w_rout;

  function automatic logic [NREG-1:0] oh(
    input logic [1:0] idx
  );
    oh = NREG'(1) << idx;
  endfunction

  assign w_cls   = r_ir[9:8];
  assign w_fnc   = r_ir[7:4];
  assign w_sub   = r_ir[7:6];
  assign w_rtype = (w_cls == 2'b00);
  assign w_move  = (w_cls == 2'b01);
  assign w_mv    = w_move && (w_sub == 2'b00);
  assign w_mvi   = w_move && (w_sub == 2'b01);

  // R-type FNc outside 0010..1011 and move sub 1x are rejected
  assign w_legal = w_rtype ? (w_fnc >= 4'd2 && w_fnc <= 4'd11)
                 : w_move  ? !w_sub[1]
                 : 1'b1;

  assign w_rx = w_rtype ? r_ir[3:2]
              : w_move  ? r_ir[5:4]
              : r_ir[7:6];
  assign w_ry = w_rtype ? r_ir[1:0] : r_ir[3:2];

  always_ff @(negedge CLKb or negedge RSTb) begin
    if (!RSTb) begin
      r_state <= S_IDLE;
      r_ir    <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (bus.PEXEC) begin
            r_ir    <= bus.INSTR;
            r_state <= S_DEC;
          end
        end
        S_DEC: begin
          if (!w_legal || w_move) r_state <= S_IDLE;
          else                    r_state <= S_T1;
        end
        S_T1:    r_state <= S_T2;
        S_T2:    r_state <= S_T3;
        S_T3:    r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_busy   = 1'b0;
    w_done   = 1'b0;
    w_err    = 1'b0;
    w_fn     = 4'b0000;
    w_ain    = 1'b0;
    w_gin    = 1'b0;
    w_gout   = 1'b0;
    w_irout  = 1'b0;
    w_immout = 1'b0;
    w_rin    = '0;
    w_rout   = '0;
    unique case (r_state)
      S_DEC: begin
        w_busy = 1'b1;
        unique case (1'b1)
          !w_legal: w_err = 1'b1;
          w_mv: begin
            w_rout = oh(w_ry);
            w_rin  = oh(w_rx);
            w_done = 1'b1;
          end
          w_mvi: begin
            w_immout = 1'b1;
            w_rin    = oh(w_rx);
            w_done   = 1'b1;
          end
          default: ;
        endcase
      end
      S_T1: begin
        w_busy = 1'b1;
        w_rout = oh(w_rx);
        w_ain  = 1'b1;
      end
      S_T2: begin
        w_busy = 1'b1;
        w_gin  = 1'b1;
        if (w_rtype) begin
          w_rout = oh(w_ry);
          w_fn   = w_fnc;
        end else begin
          w_irout = 1'b1;
          w_fn    = w_cls[0] ? 4'b0011 : 4'b0010;
        end
      end
      S_T3: begin
        w_busy = 1'b1;
        w_gout = 1'b1;
        w_rin  = oh(w_rx);
        w_done = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.BUSY   = w_busy;
  assign bus.DONE   = w_done;
  assign bus.ERR    = w_err;
  assign bus.FN     = w_fn;
  assign bus.Ain    = w_ain;
  assign bus.Gin    = w_gin;
  assign bus.Gout   = w_gout;
  assign bus.IRout  = w_irout;
  assign bus.IMMout = w_immout;
  assign bus.IMM    = {{(N-6){1'b0}}, r_ir[5:0]};
  assign bus.Rin    = w_rin;
  assign bus.Rout   = w_rout;

endmodule

// File: tb/tb_alu_sequencer.sv
// Table-driven scoreboard bench for alu_sequencer: expected
// per-cycle control snapshots are queued at issue and popped per cycle.
module tb_alu_sequencer;

  logic CLKb;
  logic RSTb;

  alu_seq_if #(.N(10), .NREG(4)) bus ();

  alu_sequencer #(.N(10), .NREG(4)) u_dut (
    .CLKb (CLKb),
    .RSTb (RSTb),
    .bus  (bus.slave)
  );

  initial CLKb = 1'b1;
  always #5 CLKb = ~CLKb;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       err;
    logic [3:0] fn;
    logic       ain;
    logic       gin;
    logic       gout;
    logic       irout;
    logic       immout;
    logic [9:0] imm;
    logic [3:0] rin;
    logic [3:0] rout;
  } snap_t;

  typedef struct {
    string      nm;
    logic [9:0] instr;
    bit         alu;
    bit         err;
    logic [3:0] fn;
    logic [3:0] rout1;
    logic [3:0] rout2;
    logic [3:0] rin;
    bit         irout;
    bit         immout;
  } vec_t;

  snap_t q[$];
  int    checks = 0;
  int    errors = 0;

  function automatic snap_t sample();
    snap_t s;
    s.busy   = bus.BUSY;
    s.done   = bus.DONE;
    s.err    = bus.ERR;
    s.fn     = bus.FN;
    s.ain    = bus.Ain;
    s.gin    = bus.Gin;
    s.gout   = bus.Gout;
    s.irout  = bus.IRout;
    s.immout = bus.IMMout;
    s.imm    = bus.IMM;
    s.rin    = bus.Rin;
    s.rout   = bus.Rout;
    return s;
  endfunction

  task automatic check(string nm, snap_t e);
    snap_t a;
    a = sample();
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, a, e);
    end
  endtask

  task automatic push_exp(vec_t v);
    snap_t s;
    s      = '0;
    s.imm  = {4'b0000, v.instr[5:0]};
    s.busy = 1'b1;
    if (v.err) begin
      s.err = 1'b1;
      q.push_back(s);
    end else if (!v.alu) begin
      s.done   = 1'b1;
      s.rout   = v.rout1;
      s.rin    = v.rin;
      s.immout = v.immout;
      q.push_back(s);
    end else begin
      q.push_back(s);
      s.rout = v.rout1;
      s.ain  = 1'b1;
      q.push_back(s);
      s.ain   = 1'b0;
      s.rout  = v.rout2;
      s.gin   = 1'b1;
      s.fn    = v.fn;
      s.irout = v.irout;
      q.push_back(s);
      s.rout  = '0;
      s.gin   = 1'b0;
      s.fn    = '0;
      s.irout = 1'b0;
      s.gout  = 1'b1;
      s.rin   = v.rin;
      s.done  = 1'b1;
      q.push_back(s);
    end
    s     = '0;
    s.imm = {4'b0000, v.instr[5:0]};
    q.push_back(s);
  endtask

  // Entered at a posedge with the DUT idle; returns at a posedge idle
  task automatic run_vec(vec_t v);
    int i;
    bus.INSTR = v.instr;
    bus.PEXEC = 1'b1;
    push_exp(v);
    @(posedge CLKb);
    bus.PEXEC = 1'b0;
    bus.INSTR = 10'($urandom);
    i = 0;
    while (q.size() > 0) begin
      check($sformatf("%s_c%0d", v.nm, i), q.pop_front());
      i++;
      if (q.size() > 0) @(posedge CLKb);
    end
  endtask

  vec_t  tbl[$];
  vec_t  v_add;
  vec_t  v_subi;
  snap_t zero;

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    zero = '0;
    //        name      instr          alu err fn    rout1   rout2   rin     ir im
    tbl.push_back('{"add",   10'b00_0010_01_10, 1, 0, 4'h2, 4'b0010, 4'b0100, 4'b0010, 0, 0});
    tbl.push_back('{"addi",  10'b10_11_000101,  1, 0, 4'h2, 4'b1000, 4'b0000, 4'b1000, 1, 0});
    tbl.push_back('{"subi",  10'b11_00_111111,  1, 0, 4'h3, 4'b0001, 4'b0000, 4'b0001, 1, 0});
    tbl.push_back('{"mvi",   10'b01_01_10_1010, 0, 0, 4'h0, 4'b0000, 4'b0000, 4'b0100, 0, 1});
    tbl.push_back('{"mv",    10'b01_00_00_11_00, 0, 0, 4'h0, 4'b1000, 4'b0000, 4'b0001, 0, 0});
    tbl.push_back('{"mvsame",10'b01_00_01_01_00, 0, 0, 4'h0, 4'b0010, 4'b0000, 4'b0010, 0, 0});
    tbl.push_back('{"ill0",  10'b00_0000_01_10, 0, 1, 4'h0, 4'b0000, 4'b0000, 4'b0000, 0, 0});
    tbl.push_back('{"illf",  10'b00_1111_11_11, 0, 1, 4'h0, 4'b0000, 4'b0000, 4'b0000, 0, 0});
    tbl.push_back('{"ill12", 10'b00_1100_00_01, 0, 1, 4'h0, 4'b0000, 4'b0000, 4'b0000, 0, 0});
    tbl.push_back('{"illmv", 10'b01_11_000000,  0, 1, 4'h0, 4'b0000, 4'b0000, 4'b0000, 0, 0});
    tbl.push_back('{"rxry",  10'b00_1011_10_10, 1, 0, 4'hB, 4'b0100, 4'b0100, 4'b0100, 0, 0});
    v_add  = tbl[0];
    v_subi = tbl[2];

    RSTb      = 1'b0;
    bus.PEXEC = 1'b0;
    bus.INSTR = '0;
    repeat (2) @(posedge CLKb);
    check("reset", zero);
    RSTb = 1'b1;
    @(posedge CLKb);
    check("reset_idle", zero);

    foreach (tbl[k]) run_vec(tbl[k]);

    // Reset asserted in the middle of an ADD's T2
    bus.INSTR = v_add.instr;
    bus.PEXEC = 1'b1;
    push_exp(v_add);
    for (int i = 0; i < 3; i++) begin
      @(posedge CLKb);
      bus.PEXEC = 1'b0;
      check($sformatf("pre_rst_c%0d", i), q.pop_front());
    end
    q.delete();
    #2 RSTb = 1'b0;
    #1 check("rst_async", zero);
    @(posedge CLKb);
    check("rst_hold", zero);
    RSTb = 1'b1;
    @(posedge CLKb);
    check("rst_release", zero);
    run_vec(v_add);

    // PEXEC held high: new INSTR ignored until the IDLE after DONE
    bus.INSTR = v_add.instr;
    bus.PEXEC = 1'b1;
    push_exp(v_add);
    push_exp(v_subi);
    @(posedge CLKb);
    for (int i = 0; q.size() > 0; i++) begin
      check($sformatf("hold_c%0d", i), q.pop_front());
      if (i == 1) bus.INSTR = v_subi.instr;
      if (i == 5) bus.PEXEC = 1'b0;
      if (q.size() > 0) @(posedge CLKb);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
Multi-cycle control unit that sits directly upstream of the multi-stage ALU. It latches a 10-bit instruction and steps the shared datapath through timing states. Each state asserts the bus-source enable, A-register load (Ain), function code (FN), result capture (Gin), result drive (Gout) and register-file write enables. It accepts one instruction per PEXEC/DONE handshake.

Parameters:
N, 10, instruction/bus width; decode fields below assume N=10.
NREG, 4, number of general registers; Rin/Rout are one-hot of this width, register fields are 2 bits.

Ports:
CLKb  in  1  clock; all state updates on falling edge.
RSTb  in  1  asynchronous active-low reset.
INSTR  in  N  instruction word, sampled only when accepted.
PEXEC  in  1  execute request.
BUSY  out  1  high from acceptance through the DONE cycle.
DONE  out  1  one-cycle pulse in the final cycle of every legal instruction.
ERR  out  1  one-cycle pulse when an illegal instruction is rejected.
FN  out  4  ALU function code.
Ain  out  1  ALU A-register load.
Gin  out  1  ALU G-register capture.
Gout  out  1  ALU result onto bus.
IRout  out  1  drive latched instruction word onto bus.
IMMout  out  1  drive IMM onto bus.
IMM  out  N  zero-extended IR[5:0].
Rin  out  NREG  one-hot register write enable.
Rout  out  NREG  one-hot register bus drive.

Behaviour:
- Reset (RSTb=0, async, also mid-instruction): state=IDLE, IR=0, all outputs 0, FN=0000. Aborted instruction has no further effect.
- IR register: loaded from INSTR only on the falling edge where state=IDLE and PEXEC=1. PEXEC in any other state is ignored; it is not queued.
- Decode fields: cls=IR[9:8]. Class 00 (R-type): FNc=IR[7:4], Rx=IR[3:2], Ry=IR[1:0]. Class 01 (move): sub=IR[7:6], Rx=IR[5:4], Ry=IR[3:2]. Classes 10/11 (ADDI/SUBI): Rx=IR[7:6], imm=IR[5:0].
- Legality: R-type requires FNc in 0010..1011. Move requires sub in {00 MV, 01 MVI}. Classes 10/11 are always legal.
- States: IDLE, DEC, T1, T2, T3.
- Outputs decode combinationally from state and IR only; they do not depend on PEXEC or INSTR. At most one bus source (Rout bit, IRout, IMMout, Gout) is active in any state.
- IDLE: all outputs 0. Goes to DEC on accept.
- DEC: BUSY=1, no datapath enables.
  - Illegal instruction: ERR=1, BUSY=1, next state IDLE.
  - MV: Rout[Ry]=1, Rin[Rx]=1, DONE=1, next state IDLE.
  - MVI: IMMout=1, Rin[Rx]=1, DONE=1, next state IDLE.
  - R-type, ADDI, SUBI: next state T1.
- T1: Rout[Rx]=1, Ain=1. Next state T2.
- T2: Gin=1.
  - R-type: Rout[Ry]=1, FN=FNc.
  - ADDI: IRout=1, FN=0010.
  - SUBI: IRout=1, FN=0011.
  - Next state T3.
- T3: Gout=1, Rin[Rx]=1, DONE=1. Next state IDLE.
- FN is 0000 in every state except T2.
- Latency from the accept edge to the DONE cycle:
  - MV / MVI / illegal: DONE (or ERR) in the first cycle after accept.
  - ALU ops: DONE in the fourth cycle after accept.
- Back-to-back: earliest next accept is the edge ending the first IDLE cycle after DONE or ERR.
- Rx==Ry is legal; T1 and T2 both drive the same register, and the ALU computes Rx op Rx.
- MV with Rx==Ry is legal and leaves the register unchanged.
- IMM is always driven as {(N-6) zeros, IR[5:0]} regardless of state.

Test Plan:
- Reset mid-T2 of ADD: assert RSTb=0 during T2 -> outputs go to 0 asynchronously; after release, state is IDLE and BUSY=0; next PEXEC is accepted normally.
- INSTR=00_0010_01_10 (ADD R1,R2) with PEXEC one cycle -> DEC: no enables; T1: Rout=0010, Ain; T2: Rout=0100, FN=0010, Gin; T3: Gout, Rin=0010, DONE; BUSY high for 4 cycles.
- INSTR=10_11_000101 (ADDI R3,#5) -> T2: IRout=1, FN=0010, Rout=0000; T3: Rin=1000, DONE. Repeat with 11_00_111111 -> FN=0011 in T2, Rin=0001 in T3.
- MVI R2,#0x2A (01_01_10_xxxx with IR[5:0]=101010) -> DEC: IMMout=1, IMM=0x02A, Rin=0100, DONE. MV R0<-R3 -> DEC: Rout=1000, Rin=0001, DONE.
- Illegal instructions: R-type FNc=0000, FNc=1111, and move sub=11 -> ERR pulse in DEC, no Rin/Gin/Ain ever asserted, state returns to IDLE.
- PEXEC held high across an ADD with a different INSTR presented during T2 -> second instruction not latched during T1..T3. It is accepted on the edge ending the first IDLE cycle after DONE, and IR equals INSTR sampled at that edge.
